// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I funct3 codes,
// responder states and the lane/extension helpers used by the datapath.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } dmem_state_t;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // sz is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic m;
    case (sz)
      2'b01:   m = off[0];
      2'b10:   m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] d;
    case (sz)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    v = {{24{b[7]}}, b};
      F3_BU:   v = {24'd0, b};
      F3_H:    v = {{16{h[15]}}, h};
      F3_HU:   v = {16'd0, h};
      default: v = word;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage with a registered read port and a byte-enabled write port.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] i_rd_idx,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_idx,
  input  logic [3:0]            i_be,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**ADDR_WIDTH];
  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_wr_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    r_q <= r_mem[i_rd_idx];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for RV32I loads/stores: fixed-latency access,
// byte/half/word lanes, load extension and misaligned/illegal-width rejection.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        fault
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  dmem_state_t           r_state, w_next_state;
  logic                  r_is_store;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_cnt;
  logic [31:0]           r_rdata;
  logic                  r_rdata_valid;
  logic                  r_fault;

  logic                  w_req;
  logic                  w_bad;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic [31:0]           w_rd_word;
  logic [31:0]           w_load_val;
  logic                  w_wr_en;
  logic                  w_unused;

  assign w_unused = &{1'b0, addr[31:ADDR_WIDTH+2]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_req        = mem_read | mem_write;
    w_bad        = !f3_legal(mem_write, funct3) || misaligned(funct3[1:0], addr[1:0]);
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        busy = w_req;
        if (w_req) w_next_state = w_bad ? ERR : WAIT;
        else       w_next_state = IDLE;
      end
      WAIT: begin
        busy = 1'b1;
        if (r_cnt == 4'd0) w_next_state = DONE;
        else               w_next_state = WAIT;
      end
      DONE:    w_next_state = IDLE;
      ERR:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_store    <= 1'b0;
      r_cnt         <= 4'd0;
      r_rdata       <= 32'd0;
      r_rdata_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_fault       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_is_store <= mem_write;
            r_funct3   <= funct3;
            r_addr     <= addr[ADDR_WIDTH+1:0];
            r_wdata    <= wdata;
            r_cnt      <= LAT_M1;
            r_fault    <= w_bad;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            if (!r_is_store) begin
              r_rdata       <= w_load_val;
              r_rdata_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read the incoming word while idle so the data is ready even when LATENCY is 1
  assign w_rd_idx   = (r_state == IDLE) ? addr[ADDR_WIDTH+1:2] : r_addr[ADDR_WIDTH+1:2];
  assign w_load_val = load_extend(r_funct3, r_addr[1:0], w_rd_word);
  assign w_wr_en    = (r_state == DONE) && r_is_store && !rst;

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk      (clk),
    .i_rd_idx (w_rd_idx),
    .i_wr_en  (w_wr_en),
    .i_wr_idx (r_addr[ADDR_WIDTH+1:2]),
    .i_be     (byte_enable(r_funct3[1:0], r_addr[1:0])),
    .i_wdata  (store_lanes(r_funct3[1:0], r_wdata)),
    .o_rdata  (w_rd_word)
  );

  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign fault       = r_fault;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset-abort
// sequence and randomized traffic against a byte-level memory model.
module tb_dmem_responder;

  localparam int AW        = 10;
  localparam int LAT       = 2;
  localparam int MEM_BYTES = 4 * (1 << AW);

  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        rdata_valid, busy, fault;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .rdata_valid(rdata_valid), .busy(busy), .fault(fault)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, wd, exp_rdata;
    logic        exp_valid, exp_fault;
    int          exp_busy;
  } vec_t;

  vec_t tbl[$];

  logic [7:0]  m_mem [MEM_BYTES];
  logic [31:0] m_rdata;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] r, logic v, logic f, int b);
    vec_t t;
    t.rd = rd; t.wr = wr; t.f3 = f3; t.a = a; t.wd = wd;
    t.exp_rdata = r; t.exp_valid = v; t.exp_fault = f; t.exp_busy = b;
    return t;
  endfunction

  task automatic do_reset;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One access from IDLE; returns what the DUT showed at completion
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int bcyc, output logic v, output logic f,
                        output logic [31:0] r, output logic stray);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    #1;
    bcyc = 0; stray = 1'b0;
    while (busy && bcyc < 40) begin
      bcyc++;
      if (rdata_valid || fault) stray = 1'b1;
      @(posedge clk); #1;
    end
    v = rdata_valid; f = fault; r = rdata;
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    if (rdata_valid || fault || busy) stray = 1'b1;
  endtask

  task automatic run_cmp(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er,
                         input logic ev, input logic ef, input int eb);
    int bc; logic v, f, s; logic [31:0] r;
    access(rd, wr, f3, a, wd, bc, v, f, r, s);
    check({tag, " busy_cycles"}, 32'(bc), 32'(eb));
    check({tag, " rdata_valid"}, {31'd0, v}, {31'd0, ev});
    check({tag, " fault"}, {31'd0, f}, {31'd0, ef});
    check({tag, " rdata"}, r, er);
    check({tag, " stray_pulse"}, {31'd0, s}, 32'd0);
  endtask

  // Reference: RV32I load/store semantics over a flat byte array
  task automatic model(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] er, output logic ev, output logic ef, output int eb);
    int size, base;
    bit legal, aligned;
    logic [31:0] val;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    aligned = (size != 0) && ((a % 32'(size)) == 32'd0);
    base  = int'(a % 32'(MEM_BYTES));
    ev = 1'b0; ef = 1'b0;
    if (!legal || !aligned) begin
      ef = 1'b1; eb = 1;
    end else begin
      eb = LAT + 1;
      if (wr) begin
        for (int k = 0; k < size; k++) m_mem[base + k] = wd[8*k +: 8];
      end else begin
        val = 32'd0;
        for (int k = 0; k < size; k++) val = val | (32'(m_mem[base + k]) << (8 * k));
        if (!f3[2] && size < 4 && val[8*size-1])
          val = val | ~((32'd1 << (8 * size)) - 32'd1);
        m_rdata = val;
        ev = 1'b1;
      end
    end
    er = m_rdata;
  endtask

  task automatic run_model(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] er; logic ev, ef; int eb;
    model(rd, wr, f3, a, wd, er, ev, ef, eb);
    run_cmp(tag, rd, wr, f3, a, wd, er, ev, ef, eb);
  endtask

  initial begin
    int bc; logic v, f, s; logic [31:0] r; logic stray;
    funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    do_reset();
    check("reset rdata", rdata, 32'd0);
    check("reset rdata_valid", {31'd0, rdata_valid}, 32'd0);
    check("reset fault", {31'd0, fault}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);

    //          rd    wr    f3    addr       wdata        exp rdata    v     f     busy
    tbl.push_back(mk(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 3));
    tbl.push_back(mk(1'b0, 1'b1, 3'd2, 32'h20, 32'h11223344, 32'hDEADBEEF, 1'b0, 1'b0, 3));
    tbl.push_back(mk(1'b0, 1'b1, 3'd0, 32'h23, 32'h12345680, 32'hDEADBEEF, 1'b0, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 32'h23, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 3'd4, 32'h23, 32'h0, 32'h00000080, 1'b1, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 32'h80223344, 1'b1, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 3'd2, 32'h02, 32'h0, 32'h80223344, 1'b0, 1'b1, 1));
    tbl.push_back(mk(1'b0, 1'b1, 3'd1, 32'h21, 32'hFFFF, 32'h80223344, 1'b0, 1'b1, 1));
    tbl.push_back(mk(1'b1, 1'b0, 3'd3, 32'h20, 32'h0, 32'h80223344, 1'b0, 1'b1, 1));
    tbl.push_back(mk(1'b0, 1'b1, 3'd4, 32'h20, 32'h0, 32'h80223344, 1'b0, 1'b1, 1));
    tbl.push_back(mk(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 32'h80223344, 1'b1, 1'b0, 3));
    tbl.push_back(mk(1'b0, 1'b1, 3'd1, 32'h22, 32'h0000BEEF, 32'h80223344, 1'b0, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 3'd1, 32'h22, 32'h0, 32'hFFFFBEEF, 1'b1, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 3'd5, 32'h22, 32'h0, 32'h0000BEEF, 1'b1, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 32'hBEEF3344, 1'b1, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b1, 3'd2, 32'h08, 32'hA5A5A5A5, 32'hBEEF3344, 1'b0, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 3'd2, 32'h08, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 3));
    tbl.push_back(mk(1'b0, 1'b1, 3'd2, 32'h1004, 32'h1, 32'hA5A5A5A5, 1'b0, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 3'd2, 32'h0004, 32'h0, 32'h00000001, 1'b1, 1'b0, 3));
    tbl.push_back(mk(1'b0, 1'b1, 3'd0, 32'h11, 32'h7F, 32'h00000001, 1'b0, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 3'd0, 32'h11, 32'h0, 32'h0000007F, 1'b1, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b1, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b1, 1'b0, 3));
    tbl.push_back(mk(1'b1, 1'b0, 3'd5, 32'h13, 32'h0, 32'hFFFFDEAD, 1'b0, 1'b1, 1));
    tbl.push_back(mk(1'b0, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 32'hFFFFDEAD, 1'b0, 1'b0, 3));

    foreach (tbl[i])
      run_cmp($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd,
              tbl[i].exp_rdata, tbl[i].exp_valid, tbl[i].exp_fault, tbl[i].exp_busy);

    // Store abandoned by reset in its second WAIT cycle must never land
    mem_write = 1'b1; funct3 = 3'd2; addr = 32'h40; wdata = 32'h12345678;
    #1 check("abort idle busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort wait2 busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_write = 1'b0;
    #1;
    check("abort idle after rst", {31'd0, busy}, 32'd0);
    check("abort rdata cleared", rdata, 32'd0);
    stray = 1'b0;
    repeat (4) begin
      if (rdata_valid || fault || busy) stray = 1'b1;
      @(posedge clk); #1;
    end
    check("abort no pulse", {31'd0, stray}, 32'd0);
    run_cmp("abort reload", 1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 3);

    // Randomized traffic: seed a 256-byte window, then mix legal/illegal accesses
    do_reset();
    m_rdata = 32'd0;
    for (int w = 0; w < 64; w++)
      run_model($sformatf("init%0d", w), 1'b0, 1'b1, 3'd2, 32'(w * 4), $urandom());
    for (int i = 0; i < 300; i++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a  = $urandom() & 32'hFFFFF0FF;
      run_model($sformatf("rnd%0d", i), op != 1, op != 0, 3'($urandom_range(0, 7)), a, $urandom());
    end

    access(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, bc, v, f, r, s);
    check("idle no request busy", 32'(bc), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
